// File: rtl/register_file_pkg.sv
// Shared constants and types for the integer register file.
package register_file_pkg;

    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned REG_COUNT = 32;
    localparam int unsigned DATA_W    = 32;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] data_word_t;

endpackage : register_file_pkg

// File: rtl/register_file_decoder.sv
// decoder_5_to_32: one-hot per-register write select.
// Ports:
//   wr_ena   - global write enable
//   wr_addr  - destination register index
//   wr_sel_c - one-hot select, bit 0 always low (x0 is not writable)
module decoder_5_to_32
    import register_file_pkg::*;
(
    input  logic                 wr_ena,
    input  reg_addr_t            wr_addr,
    output logic [REG_COUNT-1:0] wr_sel_c
);

    // Decode, then force x0 low so writes to it vanish
    always_comb begin
        wr_sel_c = '0;
        if (wr_ena) begin
            wr_sel_c[wr_addr] = 1'b1;
        end
        wr_sel_c[0] = 1'b0;
    end

endmodule : decoder_5_to_32

// File: rtl/register_file.sv
// register_file: 32 x N general-purpose registers, x0 hardwired to zero.
// Two combinational read ports, one synchronous write port.
// Ports:
//   clk, rst            - clock, synchronous active-high reset (clears x1..x31)
//   wr_ena/addr/data    - write port, commits on rising clk edge
//   rd_addr0/rd_data0   - read port 0 (combinational)
//   rd_addr1/rd_data1   - read port 1 (combinational)
module register_file #(
    parameter int unsigned N      = register_file_pkg::DATA_W,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_ena,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [N-1:0]      wr_data,
    input  logic [ADDR_W-1:0] rd_addr0,
    output logic [N-1:0]      rd_data0,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [N-1:0]      rd_data1
);

    import register_file_pkg::*;

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic [REG_COUNT-1:0] wr_sel_c;
    logic [N-1:0]         rd_vec_c [NUM_REGS];

    decoder_5_to_32 u_dec (
        .wr_ena   (wr_ena),
        .wr_addr  (wr_addr),
        .wr_sel_c (wr_sel_c)
    );

    // x0 has no storage; it reads as zero
    assign rd_vec_c[0] = '0;

    // x1..x31: enabled registers, reset wins over write
    for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
        logic [N-1:0] reg_d;
        logic [N-1:0] reg_q;

        always_comb begin
            reg_d = reg_q;
            if (wr_sel_c[i]) begin
                reg_d = wr_data;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                reg_q <= '0;
            end else begin
                reg_q <= reg_d;
            end
        end

        assign rd_vec_c[i] = reg_q;
    end

    // Read muxes: no write-through bypass, old value shows until the edge
    assign rd_data0 = rd_vec_c[rd_addr0];
    assign rd_data1 = rd_vec_c[rd_addr1];

endmodule : register_file

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: driver pushes expected reads,
// monitor pops and compares on the falling edge.
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_ena = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [4:0]  rd_addr0 = '0;
    logic [31:0] rd_data0;
    logic [4:0]  rd_addr1 = '0;
    logic [31:0] rd_data1;
    logic        chk = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] e0;
        logic [31:0] e1;
        string       name;
    } exp_t;

    exp_t        sb_q [$];
    logic [31:0] model [32];

    always #5 clk = ~clk;

    register_file dut (
        .clk      (clk),
        .rst      (rst),
        .wr_ena   (wr_ena),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr0 (rd_addr0),
        .rd_data0 (rd_data0),
        .rd_addr1 (rd_addr1),
        .rd_data1 (rd_data1)
    );

    // One cycle: drive just after the rising edge; reads are checked at the
    // falling edge (before the commit), the model commits at the next rising edge.
    task automatic step(input bit r, input bit we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] a0,
                        input logic [4:0] a1, input bit c, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst      = r;
        wr_ena   = we;
        wr_addr  = wa;
        wr_data  = wd;
        rd_addr0 = a0;
        rd_addr1 = a1;
        chk      = c;
        if (c) begin
            e.e0   = (a0 == 5'd0) ? 32'h0 : model[a0];
            e.e1   = (a1 == 5'd0) ? 32'h0 : model[a1];
            e.name = nm;
            sb_q.push_back(e);
        end
        if (r) begin
            foreach (model[k]) model[k] = 32'h0;
        end else if (we && wa != 5'd0) begin
            model[wa] = wd;
        end
    endtask

    // Monitor: compare both read ports against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty: read strobe with no expectation");
                end else begin
                    e = sb_q.pop_front();
                    if (rd_data0 !== e.e0 || rd_data1 !== e.e1) begin
                        errors++;
                        $display("FAIL %s: addr0=%0d got %h want %h, addr1=%0d got %h want %h",
                                 e.name, rd_addr0, rd_data0, e.e0, rd_addr1, rd_data1, e.e1);
                    end
                end
            end
        end
    end

    initial begin
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] rv;
        foreach (model[k]) model[k] = 32'h0;

        // Reset, then sweep all addresses on both ports
        step(1, 0, 5'd0, 32'h0, 5'd0, 5'd0, 0, "");
        for (int a = 0; a < 32; a++)
            step(0, 0, 5'd0, 32'h0, 5'(a), 5'(31 - a), 1, "reset_sweep");

        // Basic write/read
        step(0, 1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 1, "basic_before_edge");
        step(0, 0, 5'd0, 32'h0, 5'd5, 5'd5, 1, "basic_read");

        // x0 hardwire
        step(0, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1, "x0_write_cycle");
        step(0, 0, 5'd0, 32'h0, 5'd0, 5'd5, 1, "x0_read");

        // Random sweep
        for (int it = 0; it < 1000; it++) begin
            ra = 5'((it % 31) + 1);
            rv = $urandom;
            rb = 5'($urandom_range(0, 31));
            step(0, 1, ra, rv, 5'($urandom_range(0, 31)), rb, 0, "");
            step(0, 0, 5'($urandom_range(0, 31)), 32'($urandom), ra, ra, 1, "rand_same_addr");
            step(0, ($urandom_range(0, 3) == 0), rb, 32'($urandom), rb, ra, 1, "rand_mixed");
        end

        // Write disabled, then no bypass on a same-cycle read
        step(0, 0, 5'd7, 32'h12345678, 5'd7, 5'd7, 1, "wr_disabled_cycle");
        step(0, 0, 5'd0, 32'h0, 5'd7, 5'd7, 1, "wr_disabled_after");
        step(0, 1, 5'd7, 32'h12345678, 5'd7, 5'd0, 1, "no_bypass_before");
        step(0, 0, 5'd0, 32'h0, 5'd7, 5'd7, 1, "write_after_edge");

        // Reset priority over a same-cycle write
        step(0, 1, 5'd3, 32'h0F0F0F0F, 5'd3, 5'd3, 0, "");
        step(1, 1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd3, 1, "rst_prio_before");
        step(0, 0, 5'd0, 32'h0, 5'd3, 5'd7, 1, "rst_prio_after");
        for (int a = 0; a < 32; a++)
            step(0, 0, 5'd0, 32'h0, 5'(a), 5'(a), 1, "reset2_sweep");

        @(posedge clk);
        #1;
        chk = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_register_file
